// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared framing definitions for the UART packet receiver (and the future TX framer).
// Frame layout: SOF, LEN, LEN payload bytes, CSUM.
// Checksum rule: CSUM = (LEN + sum of payload bytes) mod 256.
package uart_rx_frame_ctrl_pkg;

  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         MAX_LEN_DEFAULT = 16;
  localparam int         TIMEOUT_DEFAULT = 160;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } frame_state_e;

  // Running checksum step; the 8-bit result wraps naturally
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // Address width for a buffer of the given depth, never below one bit
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, one asynchronous read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Store one payload byte per write strobe; contents need no reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_rx byte stream into packets, checks length and checksum,
// enforces an inter-byte timeout and releases good payloads on a valid/ready stream.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         MAX_LEN       = MAX_LEN_DEFAULT,
  parameter int         TIMEOUT_TICKS = TIMEOUT_DEFAULT,
  parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_ok,
  output logic       err_len,
  output logic       err_csum,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int            AW        = addr_width(MAX_LEN);
  localparam int            TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  frame_state_e  state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    rd_q, rd_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          frame_ok_q, frame_ok_d;
  logic          err_len_q, err_len_d;
  logic          err_csum_q, err_csum_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;

  logic          in_frame, timeout_hit, len_bad, csum_match, last_payload;
  logic          wr_en;
  logic [7:0]    rd_next;
  logic [AW-1:0] rd_addr;
  logic [7:0]    buf_rdata;

  assign in_frame     = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign timeout_hit  = in_frame && s_tick && !rx_done_tick && (tcnt_q == TCNT_LAST);
  assign len_bad      = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign csum_match   = (rx_data == sum_q);
  assign last_payload = (idx_q == (len_q - 8'd1));
  assign rd_next      = rd_q + 8'd1;
  // While draining, look ahead at the next byte; otherwise prefetch byte 0 for release
  assign rd_addr      = (state_q == ST_DRAIN) ? rd_next[AW-1:0] : '0;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (rx_data),
    .raddr_i (rd_addr),
    .rdata_o (buf_rdata)
  );

  // State register; a reset mid-frame simply abandons the partial packet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: walk the frame fields, bail out to IDLE on any error
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rx_done_tick && (rx_data == SOF_BYTE)) state_d = ST_LEN;
      ST_LEN:     if (rx_done_tick) state_d = len_bad ? ST_IDLE : ST_PAYLOAD;
                  else if (timeout_hit) state_d = ST_IDLE;
      ST_PAYLOAD: if (rx_done_tick) begin
                    if (last_payload) state_d = ST_CSUM;
                  end else if (timeout_hit) state_d = ST_IDLE;
      ST_CSUM:    if (rx_done_tick) state_d = csum_match ? ST_DRAIN : ST_IDLE;
                  else if (timeout_hit) state_d = ST_IDLE;
      ST_DRAIN:   if (m_valid_q && m_ready && m_last_q) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values: counters, checksum, buffer writes, stream and pulses
  always_comb begin
    len_d         = len_q;
    idx_d         = idx_q;
    rd_d          = rd_q;
    sum_d         = sum_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    frame_ok_d    = 1'b0;
    err_len_d     = 1'b0;
    err_csum_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    wr_en         = 1'b0;
    tcnt_d        = '0;

    if (in_frame) begin
      if (rx_done_tick) tcnt_d = '0;
      else if (s_tick)  tcnt_d = (tcnt_q == TCNT_LAST) ? '0 : tcnt_q + TW'(1);
      else              tcnt_d = tcnt_q;
    end

    case (state_q)
      ST_LEN: begin
        if (rx_done_tick) begin
          if (len_bad) begin
            err_len_d = 1'b1;
          end else begin
            len_d = rx_data;
            sum_d = rx_data;
            idx_d = 8'd0;
          end
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (rx_done_tick) begin
          wr_en = 1'b1;
          sum_d = csum_add(sum_q, rx_data);
          idx_d = idx_q + 8'd1;
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
        end
      end
      ST_CSUM: begin
        if (rx_done_tick) begin
          if (csum_match) begin
            m_valid_d  = 1'b1;
            frame_ok_d = 1'b1;
            rd_d       = 8'd0;
            m_data_d   = buf_rdata;
            m_last_d   = (len_q == 8'd1);
          end else begin
            err_csum_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (rx_done_tick) err_overrun_d = 1'b1;
        if (m_valid_q && m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = 8'd0;
          end else begin
            rd_d     = rd_next;
            m_data_d = buf_rdata;
            m_last_d = (rd_next == (len_q - 8'd1));
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; every output comes straight from a flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q         <= '0;
      idx_q         <= '0;
      rd_q          <= '0;
      sum_q         <= '0;
      tcnt_q        <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      frame_ok_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      len_q         <= len_d;
      idx_q         <= idx_d;
      rd_q          <= rd_d;
      sum_q         <= sum_d;
      tcnt_q        <= tcnt_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      frame_ok_q    <= frame_ok_d;
      err_len_q     <= err_len_d;
      err_csum_q    <= err_csum_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign frame_ok    = frame_ok_q;
  assign err_len     = err_len_q;
  assign err_csum    = err_csum_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frame scenarios plus randomized
// byte streams checked against a stream-level parser model.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 160;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_valid, m_last, frame_ok;
  logic       err_len, err_csum, err_timeout, err_overrun;
  logic [7:0] m_data;

  int testsRun = 0;
  int testsFailed = 0;

  logic randTick = 1'b0;
  logic randReady = 1'b0;

  int okCnt, lenCnt, csumCnt, toCnt, ovrCnt, riseCnt, multiErrCnt, badOkCnt;
  logic [8:0] obsQ[$];
  logic       prevValid = 1'b0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevLast = 1'b0;

  logic [7:0] stim[$];
  logic [8:0] expPay[$];
  int expOk, expLen, expCsum;

  wire [13:0] outVec = {m_valid, m_data, m_last, frame_ok, err_len, err_csum, err_timeout, err_overrun};

  uart_rx_frame_ctrl #(
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_TICKS (TIMEOUT),
    .SOF_BYTE      (8'hA5)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .frame_ok     (frame_ok),
    .err_len      (err_len),
    .err_csum     (err_csum),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor on the falling edge: collect transfers and pulses, verify stall stability
  always @(negedge clk) begin
    if (!reset_n) begin
      prevValid = 1'b0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_valid", 32'(m_valid), 32'd1);
        checkOutput("hold_data", 32'(m_data), 32'(prevData));
        checkOutput("hold_last", 32'(m_last), 32'(prevLast));
      end
      if (frame_ok)    okCnt++;
      if (err_len)     lenCnt++;
      if (err_csum)    csumCnt++;
      if (err_timeout) toCnt++;
      if (err_overrun) ovrCnt++;
      if ((int'(err_len) + int'(err_csum) + int'(err_timeout) + int'(err_overrun)) > 1) multiErrCnt++;
      if (m_valid && !prevValid) riseCnt++;
      if (frame_ok && !(m_valid && !prevValid)) badOkCnt++;
      if (m_valid && m_ready) obsQ.push_back({m_last, m_data});
      prevValid = m_valid;
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end
  end

  // Hard stop in case some wait never completes
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearObs();
    okCnt = 0; lenCnt = 0; csumCnt = 0; toCnt = 0; ovrCnt = 0;
    riseCnt = 0; multiErrCnt = 0; badOkCnt = 0;
    obsQ.delete();
  endtask

  // One clock of input drive, applied just after the rising edge
  task automatic driveCycle(input logic done, input logic [7:0] data, input logic tick);
    @(posedge clk); #1;
    rx_done_tick = done;
    if (done) rx_data = data;
    s_tick = tick || (randTick && ($urandom_range(0, 7) == 0));
    if (randReady) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    driveCycle(1'b1, b, 1'b0);
    driveCycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) driveCycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic tickPulse();
    driveCycle(1'b0, 8'h00, 1'b1);
    driveCycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (m_valid && budget < 2000) begin
      driveCycle(1'b0, 8'h00, 1'b0);
      budget++;
    end
    if (budget >= 2000) checkOutput("drain_budget", 32'd1, 32'd0);
  endtask

  // Feed the stim queue; optionally let each released frame drain before the next byte
  task automatic sendStream(input logic waitFlag);
    for (int k = 0; k < stim.size(); k++) begin
      sendByte(stim[k]);
      if (waitFlag) waitDrain();
    end
  endtask

  task automatic applyReset();
    reset_n = 1'b0; rx_done_tick = 1'b0; s_tick = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_outs", 32'(outVec), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    clearObs();
    #1;
  endtask

  // Reference model: scan the byte stream for frames and predict every outcome
  task automatic modelParse();
    int i, n, len, s;
    i = 0; n = stim.size();
    expPay.delete(); expOk = 0; expLen = 0; expCsum = 0;
    while (i < n) begin
      if (stim[i] != 8'hA5) begin i++; continue; end
      if (i + 1 >= n) break;
      len = int'(stim[i+1]);
      if (len == 0 || len > MAX_LEN) begin expLen++; i += 2; continue; end
      if (i + 2 + len >= n) break;
      s = len;
      for (int k = 0; k < len; k++) s += int'(stim[i+2+k]);
      if (int'(stim[i+2+len]) == (s % 256)) begin
        expOk++;
        for (int k = 0; k < len; k++) expPay.push_back({(k == len - 1), stim[i+2+k]});
      end else begin
        expCsum++;
      end
      i += len + 3;
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_ok"}, 32'(okCnt), 32'(expOk));
    checkOutput({tag, "_rise"}, 32'(riseCnt), 32'(expOk));
    checkOutput({tag, "_len"}, 32'(lenCnt), 32'(expLen));
    checkOutput({tag, "_csum"}, 32'(csumCnt), 32'(expCsum));
    checkOutput({tag, "_timeout"}, 32'(toCnt), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(ovrCnt), 32'd0);
    checkOutput({tag, "_excl"}, 32'(multiErrCnt + badOkCnt), 32'd0);
    checkOutput({tag, "_nbytes"}, 32'(obsQ.size()), 32'(expPay.size()));
    for (int k = 0; k < obsQ.size() && k < expPay.size(); k++)
      checkOutput({tag, "_byte"}, 32'(obsQ[k]), 32'(expPay[k]));
  endtask

  task automatic pushFrame(input int len, input logic corrupt);
    int s;
    logic [7:0] b;
    stim.push_back(8'hA5);
    stim.push_back(8'(len));
    s = len;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      s += int'(b);
    end
    b = 8'(s % 256);
    if (corrupt) b = b ^ 8'($urandom_range(1, 255));
    stim.push_back(b);
  endtask

  task automatic applyStimulus();
    // Good frame, then bad checksum followed by a good frame
    applyReset();
    m_ready = 1'b1;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    modelParse(); sendStream(1'b1); idle(3);
    checkAgainstModel("good");
    if (obsQ.size() == 3) begin
      checkOutput("good_first", 32'(obsQ[0]), 32'h011);
      checkOutput("good_last", 32'(obsQ[2]), 32'h133);
    end

    applyReset();
    m_ready = 1'b1;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    modelParse(); sendStream(1'b1); idle(3);
    checkAgainstModel("badcsum");

    // Length errors with trailing junk, then boundary lengths 1 and MAX_LEN
    applyReset();
    m_ready = 1'b1;
    stim = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'hA5, 8'h11, 8'h33, 8'h44};
    pushFrame(1, 1'b0);
    pushFrame(MAX_LEN, 1'b0);
    modelParse(); sendStream(1'b1); idle(3);
    checkAgainstModel("lenerr");

    // Timeout fires on the 160th silent tick
    applyReset();
    m_ready = 1'b1;
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11);
    for (int k = 0; k < TIMEOUT - 1; k++) tickPulse();
    idle(2);
    checkOutput("timeout_early", 32'(toCnt), 32'd0);
    tickPulse(); idle(2);
    checkOutput("timeout_fire", 32'(toCnt), 32'd1);
    checkOutput("timeout_excl", 32'(multiErrCnt), 32'd0);

    // A byte arriving with the 159th-count tick restarts the count
    applyReset();
    m_ready = 1'b1;
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11);
    for (int k = 0; k < TIMEOUT - 1; k++) tickPulse();
    driveCycle(1'b1, 8'h22, 1'b1);
    driveCycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < TIMEOUT - 1; k++) tickPulse();
    idle(2);
    checkOutput("tick_tie_timeout", 32'(toCnt), 32'd0);
    sendByte(8'h33); sendByte(8'h69); waitDrain(); idle(2);
    checkOutput("tick_tie_ok", 32'(okCnt), 32'd1);
    checkOutput("tick_tie_nbytes", 32'(obsQ.size()), 32'd3);

    // Backpressure for 10 cycles with an SOF injected during DRAIN
    applyReset();
    m_ready = 1'b0;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendStream(1'b0);
    idle(10);
    checkOutput("bp_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_data", 32'(m_data), 32'h11);
    sendByte(8'hA5);
    idle(1);
    checkOutput("bp_overrun", 32'(ovrCnt), 32'd1);
    m_ready = 1'b1;
    waitDrain();
    stim = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendStream(1'b1); idle(3);
    checkOutput("bp_ok", 32'(okCnt), 32'd1);
    checkOutput("bp_nbytes", 32'(obsQ.size()), 32'd3);
    if (obsQ.size() == 3) checkOutput("bp_last", 32'(obsQ[2]), 32'h133);

    // Asynchronous reset mid-payload, then a clean frame
    applyReset();
    m_ready = 1'b1;
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11);
    #2 reset_n = 1'b0;
    #1 checkOutput("rst_payload_outs", 32'(outVec), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    idle(4);
    checkOutput("rst_payload_errs", 32'(lenCnt + csumCnt + toCnt + ovrCnt), 32'd0);
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    clearObs();
    modelParse(); sendStream(1'b1); idle(3);
    checkAgainstModel("rst_next");

    // Asynchronous reset while a frame is waiting in DRAIN
    applyReset();
    m_ready = 1'b0;
    stim = '{8'hA5, 8'h02, 8'h40, 8'h50, 8'h92};
    sendStream(1'b0);
    checkOutput("rst_drain_pre", 32'(m_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 checkOutput("rst_drain_outs", 32'(outVec), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Randomized streams of good, corrupt, bad-length and junk segments
    for (int it = 0; it < 25; it++) begin
      applyReset();
      randTick = 1'b1; randReady = 1'b1;
      stim.delete();
      for (int seg = 0; seg < $urandom_range(1, 4); seg++) begin
        case ($urandom_range(0, 3))
          0: pushFrame($urandom_range(1, MAX_LEN), 1'b0);
          1: pushFrame($urandom_range(1, MAX_LEN), 1'b1);
          2: begin
            stim.push_back(8'hA5);
            stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
          end
          default: for (int j = 0; j < $urandom_range(1, 3); j++) stim.push_back(8'($urandom_range(0, 164)));
        endcase
      end
      modelParse(); sendStream(1'b1); idle(4);
      checkAgainstModel("rand");
      randTick = 1'b0; randReady = 1'b0;
    end
  endtask

  initial begin
    clearObs();
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
